instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Assembles RISC-V RV32I instruction words from decoded fields (opcode, registers, funct3/funct7, 32-bit immediate) and writes them one by one into instruction memory from a programmable base address. It inverts the decoder's opcode-to-immediate-format mapping, so its output round-trips through the processor's decode path. It sits between a host/debug loader and the instruction-memory write port, and is used to load test programs without re-synthesising memory initialisation files.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: load base_addr, clear count, arm the loader. Honoured in IDLE only.
- base_addr  in  ADDR_W  first word address to write.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  fields accepted when in_valid && in_ready.
- op  in  7  opcode.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R-type only).
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  byte-offset or value immediate.
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write on the cycle mem_we && mem_ready.
- err_valid  out  1  one-cycle pulse: the last accepted instruction was rejected.
- err_code  out  2  01 illegal opcode, 10 immediate out of range, 11 misaligned immediate; held until the next error.
- count  out  ADDR_W+1  words written since the last start.
- full  out  1  top address written; no further input is accepted until start.

## Operation
- Format from op: 0000011, 0010011, 1100111 are I (imm_sel 000); 0100011 is S (001); 1100011 is B (010); 1101111 is J (011); 0110111, 0010111 are U (100); 0110011 is R. Any other op gives error 01.
- Range checks (signed): I and S need imm in [-2048, 2047]; B needs [-4096, 4094]; J needs [-2^20, 2^20-2]. Otherwise error 10.
- Alignment checks: B and J need imm[0]=0. U needs imm[11:0]=0. Otherwise error 11. When more than one error applies, 01 takes priority over 10, and 10 over 11.
- Field packing follows standard RV32I bit placement. U places imm[31:12] at [31:12]. Unused fields are zero, so funct7 is ignored except for R.
- FSM states:
  - IDLE: in_ready = armed && !full. On accept, latch the fields and go to CHECK.
  - CHECK: register the encoded word and the error. On error go to ERR, otherwise go to WRITE.
  - ERR: err_valid = 1 for one cycle, then IDLE. Nothing is written and addr is unchanged.
  - WRITE: mem_we = 1. Hold mem_addr and mem_wdata stable until mem_ready. On handshake: addr++, count++, and full = 1 if addr was 2^ADDR_W-1. Then IDLE.
- The address does not wrap. After the top address is written, full blocks input until the next start.
- start outside IDLE is ignored. start together with in_valid in IDLE: start wins and the fields are not accepted.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, err_valid 0, err_code 00, count 0, full 0. Internal state: armed 0, FSM in IDLE.
- Accept at edge N. mem_we is high in the cycle after edge N+1, or err_valid is high in that cycle. Minimum of 3 cycles per instruction when mem_ready is tied high.
- in_ready is combinational from state, armed and full only. It does not depend on in_valid.
- An rst_n assertion mid-WRITE drops mem_we immediately (asynchronously). The loader must be re-armed with start afterwards.

## Structure
- Shared package rv_isa_pkg holds:
  - the opcode constants;
  - the imm_sel codes 000 to 100, identical to the decoder's ImmSrc;
  - the error codes;
  - the FSM state enum.
- Sub-module instr_packer is purely combinational. Inputs: op, fields, imm. Outputs: word, err, err_code. It is instantiated once, feeding the CHECK-stage registers.

## Test plan
- start with base 0x10, then ADDI x1,x0,5 (op 0010011, funct3 000, imm 5) -> mem_we with addr 0x10, wdata 0x00500093; count becomes 1.
- SW x2,8(x1) (funct3 010) -> wdata 0x0020A423. Then BEQ x0,x0,-4 -> 0xFE000EE3. Then LUI x5, imm 0x12345000 -> 0x123452B7, at consecutive addresses.
- ADDI with imm 2048 -> err_valid pulse, err_code 10, no mem_we, addr unchanged. op 1111111 -> err_code 01. BEQ with imm 3 -> err_code 11.
- Hold mem_ready low for 3 cycles during WRITE -> mem_we, mem_addr, mem_wdata stable throughout; in_ready stays 0; exactly one write.
- ADDR_W=2, base 3, one write -> full = 1, in_ready = 0. A following start with base 0 clears full and count.
- Assert rst_n low mid-WRITE -> mem_we = 0 at once and all outputs at reset values. in_valid is not accepted after reset until start is pulsed.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants for the instruction loader.
// The imm_sel codes match the decoder's ImmSrc encoding, so a loaded word decodes back to the same format.
package rv_isa_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;
  localparam logic [1:0] ERR_ALIGN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ERR,
    ST_WRITE
  } loader_state_t;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32I word assembler: picks the format from the opcode, packs the fields
// and flags illegal opcodes, out-of-range and misaligned immediates.
module instr_packer
  import rv_isa_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err,
  output logic [1:0]  err_code
);

  logic [2:0] w_sel;
  logic       w_legal;
  logic       w_rtype;
  logic       w_range_ok;
  logic       w_aligned;

  always_comb begin
    w_sel   = IMM_I;
    w_legal = 1'b1;
    w_rtype = 1'b0;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: w_sel = IMM_I;
      OP_STORE:                 w_sel = IMM_S;
      OP_BRANCH:                w_sel = IMM_B;
      OP_JAL:                   w_sel = IMM_J;
      OP_LUI, OP_AUIPC:         w_sel = IMM_U;
      OP_REG:                   w_rtype = 1'b1;
      default:                  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    word       = '0;
    w_range_ok = 1'b1;
    w_aligned  = 1'b1;
    if (w_rtype) begin
      word = {funct7, rs2, rs1, funct3, rd, op};
    end else begin
      case (w_sel)
        IMM_I: begin
          word       = {imm[11:0], rs1, funct3, rd, op};
          w_range_ok = in_range(imm, -2048, 2047);
        end
        IMM_S: begin
          word       = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
          w_range_ok = in_range(imm, -2048, 2047);
        end
        IMM_B: begin
          word       = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
          w_range_ok = in_range(imm, -4096, 4094);
          w_aligned  = ~imm[0];
        end
        IMM_J: begin
          word       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
          w_range_ok = in_range(imm, -1048576, 1048574);
          w_aligned  = ~imm[0];
        end
        IMM_U: begin
          word      = {imm[31:12], rd, op};
          w_aligned = (imm[11:0] == 12'd0);
        end
        default: word = '0;
      endcase
    end
  end

  // Opcode errors outrank range errors, which outrank alignment errors.
  assign err_code = !w_legal    ? ERR_OPCODE :
                    !w_range_ok ? ERR_RANGE  :
                    !w_aligned  ? ERR_ALIGN  : ERR_NONE;
  assign err = (err_code != ERR_NONE);

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts decoded instruction fields, encodes them and writes the words into consecutive
// instruction-memory addresses starting from the base given with start.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  loader_state_t     r_state;
  logic              r_armed;
  logic [6:0]        r_op;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [31:0]       r_imm;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_mem_we;
  logic [31:0]       r_wdata;
  logic              r_err_valid;
  logic [1:0]        r_err_code;

  logic [31:0]       w_word;
  logic              w_err;
  logic [1:0]        w_err_code;

  instr_packer u_packer (
    .op       (r_op),
    .funct3   (r_funct3),
    .funct7   (r_funct7),
    .rd       (r_rd),
    .rs1      (r_rs1),
    .rs2      (r_rs2),
    .imm      (r_imm),
    .word     (w_word),
    .err      (w_err),
    .err_code (w_err_code)
  );

  assign in_ready  = (r_state == ST_IDLE) && r_armed && !r_full;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign count     = r_count;
  assign full      = r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_op        <= '0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_wdata     <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start has priority over a simultaneous field handshake
          if (start) begin
            r_armed <= 1'b1;
            r_addr  <= base_addr;
            r_count <= '0;
            r_full  <= 1'b0;
          end else if (in_valid && in_ready) begin
            r_op     <= op;
            r_funct3 <= funct3;
            r_funct7 <= funct7;
            r_rd     <= rd;
            r_rs1    <= rs1;
            r_rs2    <= rs2;
            r_imm    <= imm;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_err) begin
            r_err_valid <= 1'b1;
            r_err_code  <= w_err_code;
            r_state     <= ST_ERR;
          end else begin
            r_wdata  <= w_word;
            r_mem_we <= 1'b1;
            r_state  <= ST_WRITE;
          end
        end
        ST_ERR: begin
          r_err_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        ST_WRITE: begin
          // the address parks at the top word instead of wrapping back to zero
          if (mem_ready) begin
            r_mem_we <= 1'b0;
            r_count  <= r_count + CNT_ONE;
            if (r_addr == TOP_ADDR) r_full <= 1'b1;
            else                    r_addr <= r_addr + ADDR_ONE;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: a transaction-level model predicts each accepted instruction's
// outcome (write or error) and a negedge monitor compares the DUT against it every cycle.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  baseAddr = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [6:0]  opIn = '0;
  logic [2:0]  funct3In = '0;
  logic [6:0]  funct7In = '0;
  logic [4:0]  rdIn = '0;
  logic [4:0]  rs1In = '0;
  logic [4:0]  rs2In = '0;
  logic [31:0] immIn = '0;
  logic        memWe;
  logic [7:0]  memAddr;
  logic [31:0] memWdata;
  logic        memReady = 1'b1;
  logic        errValid;
  logic [1:0]  errCode;
  logic [8:0]  count;
  logic        full;

  int checkCount = 0;
  int passCount = 0;
  int cycle = 0;

  typedef struct {
    bit          isErr;
    logic [1:0]  code;
    logic [31:0] word;
    logic [7:0]  addr;
    int          due;
  } expT;

  expT         expQ[$];
  bit          mArmed = 0;
  bit          mFull = 0;
  logic [7:0]  mAddr = '0;
  int          mCount = 0;
  logic [1:0]  mErrCode = '0;
  logic [7:0]  lastWriteAddr = '0;
  logic [31:0] lastWriteData = '0;
  logic [1:0]  lastErrCode = '0;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .start     (start),
    .base_addr (baseAddr),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .op        (opIn),
    .funct3    (funct3In),
    .funct7    (funct7In),
    .rd        (rdIn),
    .rs1       (rs1In),
    .rs2       (rs2In),
    .imm       (immIn),
    .mem_we    (memWe),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_ready (memReady),
    .err_valid (errValid),
    .err_code  (errCode),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passCount++;
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference encoding straight from the RV32I bit-placement rules, with error priority 01 > 10 > 11.
  function automatic void modelEncode(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [31:0] im, output logic [1:0] code, output logic [31:0] word);
    longint v;
    bit rangeOk, alignOk;
    logic [31:0] common;
    v = longint'($signed(im));
    rangeOk = 1;
    alignOk = 1;
    code = 2'd0;
    common = 32'(o) | (32'(f3) << 12) | (32'(s1) << 15);
    if (o == 7'b0000011 || o == 7'b0010011 || o == 7'b1100111) begin
      word = common | (32'(d) << 7) | ((im & 32'hFFF) << 20);
      rangeOk = (v >= -2048 && v <= 2047);
    end else if (o == 7'b0100011) begin
      word = common | ((im & 32'h1F) << 7) | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25);
      rangeOk = (v >= -2048 && v <= 2047);
    end else if (o == 7'b1100011) begin
      word = common | (((im >> 11) & 1) << 7) | (((im >> 1) & 32'hF) << 8) | (32'(s2) << 20)
           | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 1) << 31);
      rangeOk = (v >= -4096 && v <= 4094);
      alignOk = (im % 2 == 0);
    end else if (o == 7'b1101111) begin
      word = 32'(o) | (32'(d) << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 1) << 20)
           | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
      rangeOk = (v >= -1048576 && v <= 1048574);
      alignOk = (im % 2 == 0);
    end else if (o == 7'b0110111 || o == 7'b0010111) begin
      word = 32'(o) | (32'(d) << 7) | (im & 32'hFFFFF000);
      alignOk = (im % 4096 == 0);
    end else if (o == 7'b0110011) begin
      word = common | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
    end else begin
      word = 32'd0;
      code = 2'd1;
    end
    if (code == 2'd0 && !rangeOk) code = 2'd2;
    else if (code == 2'd0 && !alignOk) code = 2'd3;
  endfunction

  // Monitor: outputs are sampled on the falling edge, then the model advances for the next rising edge.
  always @(negedge clk) begin
    bit idleBefore;
    bit expReady;
    expT item;
    cycle++;
    if (!rstN) begin
      checkOutput("rstMemWe", memWe, 0);
      checkOutput("rstErrValid", errValid, 0);
      checkOutput("rstInReady", inReady, 0);
      checkOutput("rstCount", count, 0);
      checkOutput("rstFull", full, 0);
      checkOutput("rstAddr", memAddr, 0);
      checkOutput("rstWdata", memWdata, 0);
      checkOutput("rstErrCode", errCode, 0);
      expQ.delete();
      mArmed = 0; mFull = 0; mAddr = '0; mCount = 0; mErrCode = '0;
    end else begin
      idleBefore = (expQ.size() == 0);
      expReady = mArmed && !mFull && idleBefore;
      checkOutput("inReady", inReady, expReady);
      checkOutput("count", count, mCount);
      checkOutput("full", full, mFull);
      if (idleBefore || cycle < expQ[0].due) begin
        checkOutput("quietMemWe", memWe, 0);
        checkOutput("quietErrValid", errValid, 0);
        checkOutput("errCodeHeld", errCode, mErrCode);
      end else if (expQ[0].isErr) begin
        checkOutput("errValid", errValid, 1);
        checkOutput("errCode", errCode, expQ[0].code);
        checkOutput("errNoWrite", memWe, 0);
        mErrCode = expQ[0].code;
        lastErrCode = errCode;
        void'(expQ.pop_front());
      end else begin
        checkOutput("writeWe", memWe, 1);
        checkOutput("errCodeHeld", errCode, mErrCode);
        if (memWe) begin
          checkOutput("writeAddr", memAddr, expQ[0].addr);
          checkOutput("writeData", memWdata, expQ[0].word);
        end
        if (!memWe || memReady) begin
          if (memWe) begin
            lastWriteAddr = memAddr;
            lastWriteData = memWdata;
            mCount++;
            if (mAddr == 8'hFF) mFull = 1;
            else mAddr = mAddr + 8'd1;
          end
          void'(expQ.pop_front());
        end
      end
      if (start && idleBefore) begin
        mArmed = 1; mAddr = baseAddr; mCount = 0; mFull = 0;
      end else if (inValid && expReady && !start) begin
        modelEncode(opIn, funct3In, funct7In, rdIn, rs1In, rs2In, immIn, item.code, item.word);
        item.isErr = (item.code != 2'd0);
        item.addr = mAddr;
        item.due = cycle + 2;
        expQ.push_back(item);
      end
    end
  end

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] im);
    bit done;
    done = 0;
    opIn = o; funct3In = f3; funct7In = f7; rdIn = d; rs1In = s1; rs2In = s2; immIn = im;
    inValid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (inReady) done = 1;
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    if (!done) reportTimeout("acceptWait");
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) done = 1;
    end
    @(posedge clk); #1;
    if (!done) reportTimeout("idleWait");
  endtask

  task automatic pulseStart(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1; baseAddr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] randImm();
    logic [31:0] edges[14];
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, 32'd4096,
              -32'sd4096, -32'sd4097, 32'd1048574, 32'd1048576, -32'sd1048576, -32'sd1048577, 32'd3};
    case ($urandom_range(0, 3))
      0: return edges[$urandom_range(0, 13)];
      1: return 32'($signed(12'($urandom)));
      2: return $urandom & 32'hFFFFF000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] randOp();
    logic [6:0] ops[9];
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
    if ($urandom_range(0, 9) == 0) return 7'($urandom);
    return ops[$urandom_range(0, 8)];
  endfunction

  initial begin
    logic [1:0]  pinCode;
    logic [31:0] pinWord;
    bit seenWe;

    modelEncode(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, pinCode, pinWord);
    checkOutput("pinAddi", pinWord, 32'h00500093);
    modelEncode(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, pinCode, pinWord);
    checkOutput("pinSw", pinWord, 32'h0020A423);
    modelEncode(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, pinCode, pinWord);
    checkOutput("pinBeq", pinWord, 32'hFE000EE3);
    modelEncode(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, pinCode, pinWord);
    checkOutput("pinLui", pinWord, 32'h123452B7);
    modelEncode(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4095, pinCode, pinWord);
    checkOutput("pinRangeOverAlign", pinCode, 2'd2);

    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    pulseStart(8'h10);
    applyStimulus(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    waitIdle();
    checkOutput("addiAddr", lastWriteAddr, 8'h10);
    checkOutput("addiData", lastWriteData, 32'h00500093);
    checkOutput("addiCount", count, 1);
    applyStimulus(7'b0100011, 3'd2, 7'h55, 5'd0, 5'd1, 5'd2, 32'd8);
    waitIdle();
    checkOutput("swData", lastWriteData, 32'h0020A423);
    applyStimulus(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
    waitIdle();
    checkOutput("beqData", lastWriteData, 32'hFE000EE3);
    applyStimulus(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    waitIdle();
    checkOutput("luiAddr", lastWriteAddr, 8'h13);
    checkOutput("luiData", lastWriteData, 32'h123452B7);

    applyStimulus(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    waitIdle();
    checkOutput("rangeErrCode", lastErrCode, 2'd2);
    checkOutput("errAddrKept", memAddr, 8'h14);
    checkOutput("errCountKept", count, 4);
    applyStimulus(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    waitIdle();
    checkOutput("opErrCode", lastErrCode, 2'd1);
    applyStimulus(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    waitIdle();
    checkOutput("alignErrCode", lastErrCode, 2'd3);

    memReady = 1'b0;
    applyStimulus(7'b0110011, 3'd5, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
    repeat (4) @(posedge clk);
    #1 memReady = 1'b1;
    waitIdle();
    checkOutput("stallCount", count, 5);
    checkOutput("stallAddr", lastWriteAddr, 8'h14);

    pulseStart(8'hFF);
    applyStimulus(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    waitIdle();
    checkOutput("fullSet", full, 1);
    checkOutput("fullInReady", inReady, 0);
    inValid = 1'b1;
    repeat (3) @(posedge clk);
    #1 inValid = 1'b0;
    pulseStart(8'h00);
    checkOutput("fullCleared", full, 0);
    checkOutput("countCleared", count, 0);

    memReady = 1'b0;
    applyStimulus(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    seenWe = 0;
    for (int i = 0; i < 10 && !seenWe; i++) begin
      @(posedge clk); #1;
      if (memWe) seenWe = 1;
    end
    if (!seenWe) reportTimeout("weWait");
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncRstWe", memWe, 0);
    checkOutput("asyncRstAddr", memAddr, 0);
    checkOutput("asyncRstCount", count, 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    memReady = 1'b1;
    inValid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("noArmAfterRst", inReady, 0);
    inValid = 1'b0;
    pulseStart(8'h40);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      memReady = ($urandom_range(0, 3) != 0);
      inValid  = ($urandom_range(0, 2) != 0);
      start    = ($urandom_range(0, 79) == 0);
      baseAddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      opIn     = randOp();
      funct3In = 3'($urandom);
      funct7In = 7'($urandom);
      rdIn     = 5'($urandom);
      rs1In    = 5'($urandom);
      rs2In    = 5'($urandom);
      immIn    = randImm();
    end
    @(posedge clk); #1;
    inValid = 1'b0; start = 1'b0; memReady = 1'b1;
    waitIdle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
